// File: rtl/tc77_pkg.sv
// ==== tc77_pkg : shared states, bus constants and sample type for tc77_responder (rev 1.0) ====
`default_nettype none

package tc77_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_TRI   = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam int READ_BITS = 14;
  localparam int WORD_BITS = 16;

  localparam logic [15:0] CFG_SHUTDOWN   = 16'hFFFF;
  localparam logic [15:0] CFG_CONTINUOUS = 16'h0000;

  localparam logic [5:0] BITCNT_MAX = 6'd32;

  // committed conversion result as presented in read-word bits [15:2]
  typedef struct packed {
    logic [12:0] temp;
    logic        flag;
  } tc77_sample_t;

  function automatic logic [5:0] bitcnt_inc(input logic [5:0] cnt);
    return (cnt == BITCNT_MAX) ? cnt : cnt + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tc77_responder_if.sv
// ==== tc77_responder_if : TC77 three-wire bus, split into input/output halves of the SIO pin (rev 1.0) ====
`default_nettype none

interface tc77_responder_if;
  logic nTEMPCS;
  logic TEMPCLK;
  logic SIO_IN;
  logic SIO_OUT;
  logic SIO_OE;

  modport master (
    output nTEMPCS,
    output TEMPCLK,
    output SIO_IN,
    input  SIO_OUT,
    input  SIO_OE
  );

  modport slave (
    input  nTEMPCS,
    input  TEMPCLK,
    input  SIO_IN,
    output SIO_OUT,
    output SIO_OE
  );
endinterface

`default_nettype wire

// File: rtl/tc77_conv_timer.sv
// ==== tc77_conv_timer : free-running conversion counter, result/flag capture, done pulse (rev 1.0) ====
`default_nettype none

module tc77_conv_timer
  import tc77_pkg::*;
#(
  parameter logic [23:0] CONV_CYCLES = 24'd14_400_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shutdown,
  input  logic [12:0]  tempval,
  output tc77_sample_t sample,
  output logic         conv_done
);

  logic [23:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      sample    <= '0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      if (shutdown) begin
        // parked at zero so that leaving shutdown starts a full conversion
        count <= '0;
      end else if (count == CONV_CYCLES - 24'd1) begin
        count       <= '0;
        sample.temp <= tempval;
        sample.flag <= 1'b1;
        conv_done   <= 1'b1;
      end else begin
        count <= count + 24'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tc77_responder.sv
// ==== tc77_responder : TC77 device-side responder, MCLK-oversampled bus FSM plus conversion timer (rev 1.0) ====
`default_nettype none

module tc77_responder
  import tc77_pkg::*;
#(
  parameter logic [23:0] CONV_CYCLES = 24'd14_400_000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              MCLK,
  input  logic              nRESET,
  input  logic [12:0]       TEMPVAL,
  tc77_responder_if.slave   bus,
  output logic              SHUTDOWN,
  output logic              CONV_DONE
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sio_sync;
  logic                   cs_prev;
  logic                   sck_prev;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sio_sync <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0],  bus.nTEMPCS};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.TEMPCLK};
      sio_sync <= {sio_sync[SYNC_STAGES-2:0], bus.SIO_IN};
      cs_prev  <= cs_sync[SYNC_STAGES-1];
      sck_prev <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s;
  logic sck_s;
  logic sio_s;
  logic cs_fall;
  logic cs_rise;
  logic sck_rise;
  logic sck_fall;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sio_s    = sio_sync[SYNC_STAGES-1];
  assign cs_fall  =  cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev &  cs_s;
  // serial clock edges only count while the chip is selected
  assign sck_rise =  sck_s & ~sck_prev & ~cs_s;
  assign sck_fall = ~sck_s &  sck_prev & ~cs_s;

  tc77_sample_t sample;

  tc77_conv_timer #(
    .CONV_CYCLES (CONV_CYCLES)
  ) u_conv_timer (
    .clk       (MCLK),
    .rst_n     (nRESET),
    .shutdown  (SHUTDOWN),
    .tempval   (TEMPVAL),
    .sample    (sample),
    .conv_done (CONV_DONE)
  );

  logic [2:0]  state;
  logic [5:0]  bitcnt;
  logic [13:0] shadow;
  logic [14:0] cfg;
  logic [15:0] cfg_word;
  logic        sio_out;
  logic        sio_oe;

  // the 16th config bit is never stored: it completes the word in the apply cycle
  assign cfg_word    = {cfg, sio_s};
  assign bus.SIO_OUT = sio_out;
  assign bus.SIO_OE  = sio_oe;

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state    <= ST_IDLE;
      bitcnt   <= '0;
      shadow   <= '0;
      cfg      <= '0;
      sio_out  <= 1'b0;
      sio_oe   <= 1'b0;
      SHUTDOWN <= 1'b0;
    end else begin
      if (sck_rise) begin
        bitcnt <= bitcnt_inc(bitcnt);
      end

      if (cs_rise) begin
        state  <= ST_IDLE;
        sio_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              shadow  <= sample;
              bitcnt  <= '0;
              sio_oe  <= 1'b1;
              sio_out <= sample.temp[12];
              state   <= ST_READ;
            end
          end
          ST_READ: begin
            if (sck_fall) begin
              if (bitcnt == 6'(READ_BITS)) begin
                sio_oe <= 1'b0;
                state  <= ST_TRI;
              end else begin
                // rotate so the next bit is always at [12]
                sio_out <= shadow[12];
                shadow  <= {shadow[12:0], shadow[13]};
              end
            end
          end
          ST_TRI: begin
            if (sck_rise && bitcnt == 6'(WORD_BITS - 1)) begin
              state <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (sck_rise) begin
              cfg <= cfg_word[14:0];
              if (bitcnt == 6'(2 * WORD_BITS - 1)) begin
                state <= ST_HOLD;
                if (cfg_word == CFG_SHUTDOWN) begin
                  SHUTDOWN <= 1'b1;
                end else if (cfg_word == CFG_CONTINUOUS) begin
                  SHUTDOWN <= 1'b0;
                end
              end
            end
          end
          ST_HOLD: begin
            state <= ST_HOLD;
          end
          default: begin
            state  <= ST_IDLE;
            sio_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tc77_responder.sv
// ==== tb_tc77_responder : directed initiator-side checks of tc77_responder (rev 1.0) ====
`default_nettype none

module tb_tc77_responder;

  localparam logic [23:0] CC = 24'd100;
  localparam int          SS = 2;
  localparam int          HP = 5;

  logic        MCLK   = 1'b0;
  logic        nRESET = 1'b0;
  logic [12:0] TEMPVAL;
  logic        SHUTDOWN;
  logic        CONV_DONE;

  tc77_responder_if bus ();

  tc77_responder #(
    .CONV_CYCLES (CC),
    .SYNC_STAGES (SS)
  ) dut (
    .MCLK      (MCLK),
    .nRESET    (nRESET),
    .TEMPVAL   (TEMPVAL),
    .bus       (bus),
    .SHUTDOWN  (SHUTDOWN),
    .CONV_DONE (CONV_DONE)
  );

  always #5 MCLK = ~MCLK;

  int cyc = 0;
  always @(posedge MCLK) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge MCLK) if (CONV_DONE) done_cnt <= done_cnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  logic [15:0] rd_word;
  logic [15:0] rd_oe;
  logic        oe_at_end;
  int          last_rise;

  // one bus transaction of nclk serial clocks; leaves nTEMPCS high on return
  task automatic xfer(input logic [15:0] wdata, input int nclk);
    rd_word     = '0;
    rd_oe       = '0;
    bus.SIO_IN  = 1'b0;
    bus.nTEMPCS = 1'b0;
    tick(HP);
    for (int i = 0; i < nclk; i++) begin
      bus.TEMPCLK = 1'b1;
      last_rise   = cyc;
      if (i < 16) begin
        rd_word[15-i] = bus.SIO_OUT;
        rd_oe[15-i]   = bus.SIO_OE;
      end
      tick(HP);
      bus.TEMPCLK = 1'b0;
      if (i + 1 >= 16 && i + 1 < 32) bus.SIO_IN = wdata[30-i];
      tick(HP);
    end
    oe_at_end   = bus.SIO_OE;
    bus.nTEMPCS = 1'b1;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int k = 0; k < limit; k++) begin
      tick(1);
      if (CONV_DONE) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("conv_done_timeout", 0, 1);
  endtask

  int t0;
  int t1;
  int d0;

  initial begin
    bus.nTEMPCS = 1'b1;
    bus.TEMPCLK = 1'b0;
    bus.SIO_IN  = 1'b0;
    TEMPVAL     = 13'h0190;
    tick(3);
    check("rst_oe",   bus.SIO_OE,  0);
    check("rst_out",  bus.SIO_OUT, 0);
    check("rst_shdn", SHUTDOWN,    0);
    check("rst_done", CONV_DONE,   0);
    nRESET = 1'b1;

    // read before the first conversion: zero temperature, flag clear
    tick(10);
    xfer(16'h1234, 32);
    tick(HP);
    check("pre_conv_word", rd_word[15:2], 14'h0000);
    check("pre_conv_oe",   rd_oe,         16'hFFFC);
    check("odd_cfg_shdn",  SHUTDOWN,      0);

    xfer(16'h0000, 32);
    tick(HP);
    check("post_conv_word", rd_word[15:2], 14'h0321);
    check("post_conv_oe",   rd_oe,         16'hFFFC);

    wait_done(200, t0);
    wait_done(200, t1);
    check("conv_period", t1 - t0, 100);

    // negative temperature
    TEMPVAL = 13'h1FF0;
    wait_done(200, t0);
    xfer(16'h0000, 32);
    tick(HP);
    check("neg_word", rd_word[15:2], 14'h3FE1);

    // commit lands around bit 5 of the read
    TEMPVAL = 13'h0100;
    wait_done(200, t0);
    TEMPVAL = 13'h0200;
    tick(44);
    xfer(16'h0000, 32);
    tick(HP);
    check("midread_old", rd_word[15:2], 14'h0201);
    xfer(16'h0000, 32);
    tick(HP);
    check("midread_new", rd_word[15:2], 14'h0401);

    // shutdown: no conversions, result held, invalid config ignored
    xfer(16'hFFFF, 32);
    tick(HP);
    check("shdn_set", SHUTDOWN, 1);
    d0 = done_cnt;
    tick(3 * 100);
    check("shdn_no_done", done_cnt - d0, 0);
    xfer(16'h00FF, 32);
    tick(HP);
    check("shdn_hold_word", rd_word[15:2], 14'h0401);
    check("shdn_invalid",   SHUTDOWN,      1);
    xfer(16'h0000, 32);
    wait_done(300, t0);
    check("wake_latency", t0 - last_rise, 103);
    check("shdn_clear",   SHUTDOWN,       0);

    // aborts: partial write of ones, then abort during the read phase
    xfer(16'hFFFF, 20);
    tick(HP);
    check("abort_wr_shdn", SHUTDOWN, 0);
    xfer(16'h0000, 5);
    check("abort_rd_oe_before", oe_at_end, 1);
    tick(SS + 2);
    check("abort_rd_oe_after", bus.SIO_OE, 0);
    tick(HP);
    xfer(16'h00FF, 32);
    tick(HP);
    check("recover_word",  rd_word[15:2], 14'h0401);
    check("invalid_shdn",  SHUTDOWN,      0);

    // asynchronous reset mid-read
    bus.nTEMPCS = 1'b0;
    tick(HP);
    check("arst_oe_before", bus.SIO_OE, 1);
    #3;
    nRESET = 1'b0;
    #1;
    check("arst_oe_async", bus.SIO_OE, 0);
    bus.nTEMPCS = 1'b1;
    tick(3);
    nRESET = 1'b1;
    tick(5);
    xfer(16'h0000, 32);
    tick(HP);
    check("arst_flag_word", rd_word[15:2], 14'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
